// File: rtl/ping_pong_checker_pkg.sv
// Shared definitions for the ping-pong counter checker: direction encoding,
// checker FSM states and the default error-counter width.
package ping_pong_checker_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int ERR_W_DEFAULT = 8;

    typedef enum logic [0:0] {
        S_SYNC  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

endpackage

// File: rtl/ping_pong_checker_model.sv
// Combinational next-state function of the ping-pong counter; usable as a
// golden reference wherever the counter needs to be predicted.
module ping_pong_model
    import ping_pong_checker_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] cur_out,
    input  logic             cur_dir,
    input  logic             enable,
    input  logic             flip,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] min,
    output logic [WIDTH-1:0] nxt_out,
    output logic             nxt_dir
);

    localparam logic [WIDTH-1:0] STEP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic range_ok_s;
    logic step_dir_s;

    // Next out/direction; boundary turnaround wins over a flip request.
    always_comb begin
        nxt_out    = cur_out;
        nxt_dir    = cur_dir;
        step_dir_s = cur_dir;
        range_ok_s = (max > min) && (cur_out >= min) && (cur_out <= max);
        if (!enable || !range_ok_s) begin
            nxt_out = cur_out;
            nxt_dir = cur_dir;
        end else if (cur_out == max) begin
            nxt_dir = DIR_DOWN;
            nxt_out = cur_out - STEP_ONE;
        end else if (cur_out == min) begin
            nxt_dir = DIR_UP;
            nxt_out = cur_out + STEP_ONE;
        end else begin
            if (flip) begin
                step_dir_s = ~cur_dir;
            end else begin
                step_dir_s = cur_dir;
            end
            nxt_dir = step_dir_s;
            if (step_dir_s == DIR_UP) begin
                nxt_out = cur_out + STEP_ONE;
            end else begin
                nxt_out = cur_out - STEP_ONE;
            end
        end
    end

endmodule

// File: rtl/ping_pong_checker.sv
// Passive checker beside a ping-pong counter: predicts each observed sample,
// flags mismatches and resynchronizes so one fault yields one error pulse.
module ping_pong_checker
    import ping_pong_checker_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ERR_W = ERR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             flip,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] min,
    input  logic [WIDTH-1:0] out_obs,
    input  logic             dir_obs,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] err_out,
    output logic             err_dir
);

    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_SAT = {ERR_W{1'b1}};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] pred_out_r;
    logic             pred_dir_r;
    logic [WIDTH-1:0] base_out_s;
    logic             base_dir_s;
    logic [WIDTH-1:0] model_out_s;
    logic             model_dir_s;
    logic             mismatch_s;
    logic             locked_r;
    logic             err_r;
    logic [ERR_W-1:0] err_count_r;
    logic [WIDTH-1:0] err_out_r;
    logic             err_dir_r;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] value);
        if (value == ERR_SAT) begin
            return value;
        end else begin
            return value + ERR_ONE;
        end
    endfunction

    // The model always steps from a base that equals the observed sample
    // whenever the prediction was wrong (or not yet established).
    ping_pong_model #(
        .WIDTH (WIDTH)
    ) u_model (
        .cur_out (base_out_s),
        .cur_dir (base_dir_s),
        .enable  (enable),
        .flip    (flip),
        .max     (max),
        .min     (min),
        .nxt_out (model_out_s),
        .nxt_dir (model_dir_s)
    );

    // Next-state, compare and model-base selection.
    always_comb begin
        state_nxt_s = state_r;
        base_out_s  = out_obs;
        base_dir_s  = dir_obs;
        mismatch_s  = 1'b0;
        case (state_r)
            S_SYNC: begin
                state_nxt_s = S_TRACK;
                base_out_s  = out_obs;
                base_dir_s  = dir_obs;
                mismatch_s  = 1'b0;
            end
            S_TRACK: begin
                state_nxt_s = S_TRACK;
                mismatch_s  = (out_obs != pred_out_r) || (dir_obs != pred_dir_r);
                if (mismatch_s) begin
                    base_out_s = out_obs;
                    base_dir_s = dir_obs;
                end else begin
                    base_out_s = pred_out_r;
                    base_dir_s = pred_dir_r;
                end
            end
            default: begin
                state_nxt_s = S_SYNC;
                base_out_s  = out_obs;
                base_dir_s  = dir_obs;
                mismatch_s  = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_SYNC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Prediction of the sample the counter will present at the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_out_r <= {WIDTH{1'b0}};
            pred_dir_r <= DIR_UP;
        end else begin
            pred_out_r <= model_out_s;
            pred_dir_r <= model_dir_s;
        end
    end

    // Registered status and error reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_r    <= 1'b0;
            err_r       <= 1'b0;
            err_count_r <= {ERR_W{1'b0}};
            err_out_r   <= {WIDTH{1'b0}};
            err_dir_r   <= 1'b0;
        end else begin
            locked_r <= (state_nxt_s == S_TRACK);
            err_r    <= mismatch_s;
            if (mismatch_s) begin
                err_count_r <= sat_inc(err_count_r);
                err_out_r   <= pred_out_r;
                err_dir_r   <= pred_dir_r;
            end
        end
    end

    assign locked    = locked_r;
    assign err       = err_r;
    assign err_count = err_count_r;
    assign err_out   = err_out_r;
    assign err_dir   = err_dir_r;

endmodule

// File: tb/tb_ping_pong_checker.sv
// Directed bench for ping_pong_checker: drives a well-behaved counter sequence,
// then flips, injected faults, invalid ranges, saturation and mid-run reset.
module tb_ping_pong_checker;

    localparam int WIDTH = 4;
    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             flip;
    logic [WIDTH-1:0] max;
    logic [WIDTH-1:0] min;
    logic [WIDTH-1:0] out_obs;
    logic             dir_obs;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] err_out;
    logic             err_dir;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [WIDTH-1:0] c_out;
    logic             c_dir;
    logic [WIDTH-1:0] hold_val;
    int               guard;

    ping_pong_checker #(
        .WIDTH (WIDTH),
        .ERR_W (ERR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .flip      (flip),
        .max       (max),
        .min       (min),
        .out_obs   (out_obs),
        .dir_obs   (dir_obs),
        .locked    (locked),
        .err       (err),
        .err_count (err_count),
        .err_out   (err_out),
        .err_dir   (err_dir)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        out_obs = c_out;
        dir_obs = c_dir;
    endtask

    // Behaviour of a correct counter, used only to generate stimulus.
    task automatic cnt_advance();
        if (enable && (max > min) && (c_out >= min) && (c_out <= max)) begin
            if (c_out == max) begin
                c_dir = 1'b0;
                c_out = c_out - 4'd1;
            end else if (c_out == min) begin
                c_dir = 1'b1;
                c_out = c_out + 4'd1;
            end else begin
                if (flip) c_dir = ~c_dir;
                c_out = c_dir ? c_out + 4'd1 : c_out - 4'd1;
            end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; flip = 1'b0;
        max = 4'd0; min = 4'd0; out_obs = 4'd0; dir_obs = 1'b0;
        c_out = 4'd0; c_dir = 1'b1;
        repeat (2) tick();
        check_eq("rst_locked", 32'(locked), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_count", 32'(err_count), 32'd0);
        check_eq("rst_err_out", 32'(err_out), 32'd0);
        check_eq("rst_err_dir", 32'(err_dir), 32'd0);

        // Correct counter, full range
        rst = 1'b0; max = 4'd15; min = 4'd0; enable = 1'b1; flip = 1'b0;
        c_out = 4'd0; c_dir = 1'b1;
        apply();
        check_eq("sync_unlocked", 32'(locked), 32'd0);
        tick();
        check_eq("sync_locked", 32'(locked), 32'd1);
        cnt_advance();
        for (int i = 0; i < 40; i++) begin
            apply(); tick();
            check_eq("run_err", 32'(err), 32'd0);
            cnt_advance();
        end
        check_eq("run_locked", 32'(locked), 32'd1);
        check_eq("run_count", 32'(err_count), 32'd0);

        // Flip at 7 while counting up
        guard = 0;
        while (!(c_out == 4'd7 && c_dir == 1'b1) && guard < 64) begin
            apply(); tick(); cnt_advance(); guard++;
        end
        check_eq("flip_reach", 32'(guard < 64), 32'd1);
        flip = 1'b1;
        apply(); tick();
        check_eq("flip_cycle_err", 32'(err), 32'd0);
        cnt_advance();
        flip = 1'b0;
        out_obs = 4'd6; dir_obs = 1'b0;
        tick();
        check_eq("flip_accept_err", 32'(err), 32'd0);
        c_out = 4'd6; c_dir = 1'b0;
        cnt_advance();
        for (int i = 0; i < 3; i++) begin
            apply(); tick();
            check_eq("post_flip_err", 32'(err), 32'd0);
            cnt_advance();
        end
        check_eq("flip_count", 32'(err_count), 32'd0);

        // Force 9 where 5 (up) is expected
        guard = 0;
        while (!(c_out == 4'd5 && c_dir == 1'b1) && guard < 64) begin
            apply(); tick(); cnt_advance(); guard++;
        end
        check_eq("fault_reach", 32'(guard < 64), 32'd1);
        c_out = 4'd9;
        apply(); tick();
        check_eq("fault_err", 32'(err), 32'd1);
        check_eq("fault_err_out", 32'(err_out), 32'd5);
        check_eq("fault_err_dir", 32'(err_dir), 32'd1);
        check_eq("fault_count", 32'(err_count), 32'd1);
        cnt_advance();
        for (int i = 0; i < 10; i++) begin
            apply(); tick();
            check_eq("resume_err", 32'(err), 32'd0);
            cnt_advance();
        end
        check_eq("resume_count", 32'(err_count), 32'd1);

        // Invalid range: model holds
        max = 4'd3; min = 4'd5;
        apply(); tick();
        check_eq("inv_hold0_err", 32'(err), 32'd0);
        cnt_advance();
        apply(); tick();
        check_eq("inv_hold1_err", 32'(err), 32'd0);
        hold_val = c_out;
        c_out = c_out + 4'd1;
        apply(); tick();
        check_eq("inv_move_err", 32'(err), 32'd1);
        check_eq("inv_move_err_out", 32'(err_out), 32'(hold_val));
        check_eq("inv_move_count", 32'(err_count), 32'd2);
        apply(); tick();
        check_eq("inv_rehold_err", 32'(err), 32'd0);
        check_eq("inv_rehold_count", 32'(err_count), 32'd2);

        // 300 consecutive mismatches saturate the counter
        for (int i = 0; i < 300; i++) begin
            c_out = c_out ^ 4'd1;
            apply(); tick();
        end
        check_eq("sat_count", 32'(err_count), 32'd255);
        check_eq("sat_err", 32'(err), 32'd1);

        // Mid-run reset with err_count = 3
        rst = 1'b1; tick(); rst = 1'b0;
        max = 4'd3; min = 4'd5; enable = 1'b1;
        c_out = 4'd0; c_dir = 1'b1;
        apply(); tick();
        check_eq("rs_locked", 32'(locked), 32'd1);
        check_eq("rs_count0", 32'(err_count), 32'd0);
        c_out = 4'd1; apply(); tick();
        c_out = 4'd2; apply(); tick();
        c_dir = 1'b0; apply(); tick();
        check_eq("rs_count3", 32'(err_count), 32'd3);
        check_eq("rs_dir_err_out", 32'(err_out), 32'd2);
        check_eq("rs_dir_err_dir", 32'(err_dir), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_locked", 32'(locked), 32'd0);
        check_eq("mid_rst_err", 32'(err), 32'd0);
        check_eq("mid_rst_count", 32'(err_count), 32'd0);
        check_eq("mid_rst_err_out", 32'(err_out), 32'd0);
        check_eq("mid_rst_err_dir", 32'(err_dir), 32'd0);
        tick();
        rst = 1'b0;
        c_out = 4'd4; c_dir = 1'b0;
        apply();
        check_eq("resync_unlocked", 32'(locked), 32'd0);
        tick();
        check_eq("resync_locked", 32'(locked), 32'd1);
        check_eq("resync_err", 32'(err), 32'd0);
        tick();
        check_eq("resync_hold_err", 32'(err), 32'd0);
        check_eq("resync_count", 32'(err_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ping_pong_checker.md
Name: ping_pong_checker

Overview:
- Passive observer at the consumer end of the parameterized ping-pong counter interface.
- Samples the counter's control inputs (enable, flip, max, min) and outputs (out, direction) every clock.
- Runs its own reference model of the counter, compares the prediction against what the counter actually produced, and reports mismatches.
- Instantiated beside the counter in lab benches and on-board self-test builds.

Parameters:
- WIDTH, 4, width of max/min/out.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  counter enable, as driven to the counter.
- flip  input  1  counter flip request, as driven to the counter.
- max  input  WIDTH  counter upper bound.
- min  input  WIDTH  counter lower bound.
- out_obs  input  WIDTH  counter out, observed.
- dir_obs  input  1  counter direction, observed (1 = up, 0 = down).
- locked  output  1  model synchronized and tracking.
- err  output  1  one-cycle pulse per detected mismatch.
- err_count  output  ERR_W  number of mismatches, saturating.
- err_out  output  WIDTH  expected out at the most recent mismatch.
- err_dir  output  1  expected direction at the most recent mismatch.

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- Reset values: locked = 0, err = 0, err_count = 0, err_out = 0, err_dir = 0, model state = 0 / up, FSM = SYNC.
- FSM states:
  - SYNC: on the first rising edge after rst deasserts, load exp_out = out_obs and exp_dir = dir_obs, no compare, then go to TRACK.
  - TRACK: compare every cycle; locked = 1 while in TRACK.
- Model step, computed from the values sampled at edge n to predict the sample at edge n+1:
  - Range valid means max > min and min <= exp_out <= max (unsigned compare).
  - If enable = 0 or range invalid: next out = exp_out, next direction = exp_dir.
  - Else if exp_out == max: direction becomes down, out becomes exp_out - 1.
  - Else if exp_out == min: direction becomes up, out becomes exp_out + 1.
  - Else if flip = 1: direction inverts, then out steps one in the new direction.
  - Else: out steps one in exp_dir.
  - Boundary turnaround takes priority over flip.
- Arithmetic: all WIDTH-bit unsigned. No wrap is reachable inside a valid range; the steps are ±1 only.
- Compare, in TRACK at each edge:
  - Mismatch = (out_obs != exp_out) or (dir_obs != exp_dir).
  - On mismatch: err = 1 in the following cycle (registered, latency 1); err_out and err_dir capture exp_out and exp_dir; err_count increments, holding at 2^ERR_W - 1.
  - After a mismatch the model resynchronizes: its next step is computed from out_obs / dir_obs rather than the stale prediction. One fault gives one err pulse, not a cascade.
  - On match: the model advances from exp_out / exp_dir.
- Input changes: a change of max/min mid-run takes effect on the next step; no special handling.
- Reset mid-operation: immediate return to reset values and SYNC; err_count is cleared.
- Counter reset not visible to the checker: the mismatch it produces is reported once, then tracking resumes.

Decomposition:
- Shared package/header holds:
  - DIR_UP = 1 and DIR_DOWN = 0;
  - the FSM state encodings S_SYNC and S_TRACK;
  - the ERR_W default.
- One natural sub-module: ping_pong_model. It is combinational next-state logic with inputs (cur_out, cur_dir, enable, flip, max, min) and outputs (nxt_out, nxt_dir).
- The same sub-module is reusable as a golden model in other benches.

Test Plan:
- max = 15, min = 0, enable = 1, flip = 0, correct counter for 40 cycles -> locked = 1 from cycle 2, err never asserts, err_count = 0.
- Flip pulse at out = 7 while counting up -> next observed 6 / down is accepted; err stays 0.
- Force out_obs to 9 when 5 is expected -> err pulses exactly once, err_out = 5, err_count = 1, and no further errors as tracking resumes from 9.
- max = 3, min = 5 (invalid) with enable = 1 -> model holds; a counter that changes out gives err, a holding counter gives no err.
- Inject 300 consecutive mismatches -> err_count saturates at 255.
- Assert rst mid-run with err_count = 3 -> all outputs go to 0 immediately, locked = 0; after release, re-sync takes one cycle and then locked = 1.
